// File: rtl/dar_arbiter.sv
// Two-requester round-robin arbiter in front of a 128x8 register file, with a
// background sweep that zeroes every entry on request.
module dar_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_rvalid,
    output logic       b_rvalid,
    output logic [7:0] a_rdata,
    output logic [7:0] b_rdata,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic       clr_done,
    output logic       mem_w_en,
    output logic       mem_r_en,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       ptr;
    logic [6:0] clr_cnt;
    logic       clr_pend;
    logic       lat_id;
    logic       lat_we;
    logic [6:0] lat_addr;
    logic [7:0] lat_wdata;
    logic       clear_now;
    logic       any_req;
    logic       win_id;
    logic       clr_last;

    // A clr_req arriving in IDLE counts immediately so it beats a same-cycle request
    always_comb begin
        clear_now = clr_pend | clr_req;
        any_req   = a_req | b_req;
        win_id    = (a_req && b_req) ? ptr : b_req;
        clr_last  = (clr_cnt == 7'd127);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear_now) begin
                    state_nxt = CLEAR;
                end else if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = IDLE;
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grants and the register-file port are decoded from the current state only
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        clr_busy  = 1'b0;
        mem_w_en  = 1'b0;
        mem_r_en  = 1'b0;
        mem_addr  = 7'd0;
        mem_wdata = 8'd0;
        case (state)
            ACCESS: begin
                a_gnt    = ~lat_id;
                b_gnt    = lat_id;
                mem_addr = lat_addr;
                mem_w_en = lat_we;
                mem_r_en = ~lat_we;
                if (lat_we) begin
                    mem_wdata = lat_wdata;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                mem_w_en = 1'b1;
                mem_addr = clr_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 7'd0;
            lat_wdata <= 8'd0;
        end else if (state == IDLE && !clear_now && any_req) begin
            lat_id    <= win_id;
            lat_we    <= win_id ? b_we    : a_we;
            lat_addr  <= win_id ? b_addr  : a_addr;
            lat_wdata <= win_id ? b_wdata : a_wdata;
        end
    end

    // Priority passes to whichever requester was not just served
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (state == ACCESS) begin
            ptr <= ~lat_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt  <= 7'd0;
            clr_pend <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 7'd1;
                if (clr_last) begin
                    clr_pend <= 1'b0;
                    clr_done <= 1'b1;
                end
            end else if (clr_req) begin
                clr_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= 8'd0;
            b_rdata  <= 8'd0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (state == ACCESS && !lat_we) begin
                if (lat_id) begin
                    b_rdata  <= mem_rdata;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= mem_rdata;
                    a_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dar_arbiter.md
DAR_ARBITER -- requirements
Module: dar_arbiter

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-low, and it SHALL have no parameters: the address width is fixed at 7 bits (128 entries) and the data width at 8 bits.
REQ-002 clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous active-low reset; sampled only at posedge clk.
REQ-004 a_req, b_req  in  1  access request from requester A or B; held high until the matching gnt.
REQ-005 a_we, b_we  in  1  request type: 1 = write, 0 = read; stable while req is high.
REQ-006 a_addr, b_addr  in  7  target entry; stable while req is high.
REQ-007 a_wdata, b_wdata  in  8  write data; stable while req is high.
REQ-008 a_gnt, b_gnt  out  1  one-cycle pulse during that requester's access cycle.
REQ-009 a_rvalid, b_rvalid  out  1  one-cycle pulse, one cycle after a read gnt.
REQ-010 a_rdata, b_rdata  out  8  registered read data; valid when rvalid is high, holds its value otherwise.
REQ-011 clr_req  in  1  request to zero all 128 entries; pulse or level.
REQ-012 clr_busy  out  1  high while the clear sweep runs.
REQ-013 clr_done  out  1  one-cycle pulse after the last clear write.
REQ-014 mem_w_en, mem_r_en  out  1  register-file write and read enables.
REQ-015 mem_addr  out  7  register-file address.
REQ-016 mem_wdata  out  8  register-file write data.
REQ-017 mem_rdata  in  8  register-file read data; combinational from mem_addr when mem_r_en is high.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and CLEAR.
REQ-019 In IDLE, if a clear is pending, the next state SHALL be CLEAR; clear has priority over requests.
REQ-020 Else in IDLE, if any req is high, the block SHALL latch the winner's we/addr/wdata and the winner id, and the next state SHALL be ACCESS.
REQ-021 Arbitration SHALL be round-robin with a 1-bit priority pointer: a lone requester wins regardless of the pointer; on simultaneous requests the pointer holder wins.
REQ-022 After each ACCESS, the pointer SHALL move to the requester that was not served.
REQ-023 In ACCESS, the block SHALL drive mem_addr with the latched addr, and either mem_w_en = 1 with mem_wdata = latched wdata (write), or mem_r_en = 1 (read).
REQ-024 In ACCESS, the block SHALL pulse the winner's gnt and SHALL return to IDLE at the next posedge.
REQ-025 On a read, the block SHALL capture mem_rdata into the winner's rdata at the end of ACCESS and SHALL pulse the winner's rvalid in the following cycle.
REQ-026 Request-to-gnt latency SHALL be 1 cycle minimum; request-to-rvalid latency SHALL be 2 cycles minimum; throughput SHALL be one access per 2 cycles.
REQ-027 Outside ACCESS and CLEAR, mem_w_en, mem_r_en, mem_addr and mem_wdata SHALL all be 0.
REQ-028 A clr_req seen in any state other than CLEAR SHALL set a pending flag; clr_req during CLEAR SHALL be ignored.
REQ-029 In CLEAR, a 7-bit counter SHALL step from 0 to 127 with mem_w_en = 1, mem_addr = counter, mem_wdata = 0, and clr_busy = 1, for 128 cycles.
REQ-030 After the write at address 127, the block SHALL clear the pending flag, return to IDLE and pulse clr_done in the next cycle; the counter SHALL wrap to 0.
REQ-031 Requests raised during CLEAR SHALL wait; no gnt SHALL be issued while clr_busy is high.
REQ-032 Requesters SHALL NOT see a gnt for a request that was deasserted before arbitration; the block SHALL sample req only in IDLE.

Reset
REQ-033 When rst = 0 at posedge clk: state = IDLE, pointer = A, clear counter = 0, clear pending = 0, latched request fields = 0.
REQ-034 When rst = 0 at posedge clk: all outputs = 0, including a_rdata and b_rdata.
REQ-035 A reset during ACCESS or CLEAR SHALL abort the operation with no gnt, rvalid or clr_done afterwards; entries already cleared stay cleared.

Verification
REQ-036 Single write then read: A writes 0x5A to addr 0x10; A reads addr 0x10 -> a_gnt at cycle +1 for each request, a_rvalid at cycle +2 of the read, a_rdata = 0x5A; b_gnt never asserted.
REQ-037 Round-robin: a_req and b_req held high for 4 accesses from reset -> grant order A, B, A, B, with gnts 2 cycles apart.
REQ-038 Clear priority: clr_req arrives together with a_req -> clr_busy high for 128 cycles, mem_addr sweeps 0..127, clr_done pulses once, then a_gnt; a subsequent read of any address returns 0x00.
REQ-039 clr_req during ACCESS -> clear starts immediately after that access finishes; a second clr_req during CLEAR -> only one clr_done.
REQ-040 Reset mid-clear: rst = 0 at counter = 50 -> all outputs 0, clr_done never pulses; a new clr_req restarts the sweep at address 0.
REQ-041 Read of B while A waits: b_req is a read of addr 0x7F holding 0x33 and a_req arrives during B's access -> b_rdata = 0x33 with b_rvalid, and a_gnt in the cycle after B's return to IDLE.
